// File: rtl/fc_sched_pkg.sv
// Shared types and constants for the FC-layer pass scheduler.
package fc_sched_pkg;

  localparam int LANES_DEF = 4;
  localparam int DW_DEF    = 8;
  localparam int BEATS_DEF = 16;

  localparam logic [1:0] CLS_ABNORMAL = 2'd0;
  localparam logic [1:0] CLS_NORMAL   = 2'd1;
  localparam logic [1:0] CLS_NONE     = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_STREAM   = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/fc_scheduler_if.sv
// Feature-buffer read bus, FC datapath lanes and result handshake of the scheduler.
interface fc_scheduler_if
  import fc_sched_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = $clog2(BEATS_DEF)
);

  logic                  mem_rd_en;
  logic [AW-1:0]         mem_addr;
  logic [LANES*DW-1:0]   mem_rdata;
  logic                  fc_en;
  logic [LANES*DW-1:0]   fc_in;
  logic [1:0]            fc_outfin;
  logic                  res_valid;
  logic                  res_ready;
  logic [1:0]            res_class;
  logic                  res_err;

  modport master (
    output mem_rd_en, mem_addr, fc_en, fc_in, res_valid, res_class, res_err,
    input  mem_rdata, fc_outfin, res_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, fc_en, fc_in, res_valid, res_class, res_err,
    output mem_rdata, fc_outfin, res_ready
  );

endinterface

// File: rtl/fc_stat_counter.sv
// Saturating event counter; a synchronous clear wins over a same-cycle increment.
module fc_stat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr) begin
      cnt_next_s = '0;
    end else if (inc && (cnt_r != {CW{1'b1}})) begin
      cnt_next_s = cnt_r + 1'b1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // counter register, written every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/fc_scheduler.sv
// Streams the pooled feature vector into the FC layer, captures its class decision
// and offers it downstream over valid/ready, keeping per-class statistics.
module fc_scheduler
  import fc_sched_pkg::*;
#(
  parameter int BEATS   = BEATS_DEF,
  parameter int AW      = $clog2(BEATS_DEF),
  parameter int TIMEOUT = 8,
  parameter int CW      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           stat_clr,
  output logic           busy,
  output logic [CW-1:0]  normal_cnt,
  output logic [CW-1:0]  abnormal_cnt,
  fc_scheduler_if.master bus
);

  localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
  localparam logic [TW-1:0] LAST_TMO  = TW'(TIMEOUT - 1);

  state_t        state_r, state_next_s;
  logic [AW-1:0] beat_r, beat_next_s;
  logic [TW-1:0] tmo_r, tmo_next_s;
  logic [1:0]    class_r, class_next_s;
  logic          err_r, err_next_s;

  logic          busy_r, busy_next_s;
  logic          rd_en_r, rd_en_next_s;
  logic [AW-1:0] addr_r, addr_next_s;
  logic          fc_en_r, fc_en_next_s;
  logic          valid_r, valid_next_s;
  logic          fire_s;

  // next state and captured result; abort overrides every transition
  always_comb begin
    state_next_s = state_r;
    beat_next_s  = beat_r;
    tmo_next_s   = tmo_r;
    class_next_s = class_r;
    err_next_s   = err_r;
    if (abort) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_next_s = ST_PREFETCH;
          else       state_next_s = ST_IDLE;
        end
        ST_PREFETCH: begin
          state_next_s = ST_STREAM;
          beat_next_s  = '0;
        end
        ST_STREAM: begin
          if (beat_r == LAST_BEAT) begin
            state_next_s = ST_WAIT_RES;
            tmo_next_s   = '0;
          end else begin
            beat_next_s  = beat_r + 1'b1;
          end
        end
        ST_WAIT_RES: begin
          if (bus.fc_outfin != CLS_NONE) begin
            state_next_s = ST_DONE;
            class_next_s = bus.fc_outfin;
            err_next_s   = 1'b0;
          end else if (tmo_r == LAST_TMO) begin
            state_next_s = ST_DONE;
            class_next_s = CLS_NONE;
            err_next_s   = 1'b1;
          end else begin
            tmo_next_s   = tmo_r + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) state_next_s = ST_IDLE;
          else               state_next_s = ST_DONE;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // outputs are registered, so they are derived from the state being entered
  always_comb begin
    busy_next_s  = (state_next_s != ST_IDLE);
    fc_en_next_s = (state_next_s == ST_STREAM) || (state_next_s == ST_WAIT_RES) ||
                   (state_next_s == ST_DONE);
    valid_next_s = (state_next_s == ST_DONE);
    rd_en_next_s = 1'b0;
    addr_next_s  = '0;
    if (state_next_s == ST_PREFETCH) begin
      rd_en_next_s = 1'b1;
      addr_next_s  = '0;
    end else if ((state_next_s == ST_STREAM) && (beat_next_s != LAST_BEAT)) begin
      rd_en_next_s = 1'b1;
      addr_next_s  = beat_next_s + 1'b1;
    end else begin
      rd_en_next_s = 1'b0;
      addr_next_s  = '0;
    end
  end

  // state, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      beat_r  <= '0;
      tmo_r   <= '0;
      class_r <= 2'd0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rd_en_r <= 1'b0;
      addr_r  <= '0;
      fc_en_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      beat_r  <= beat_next_s;
      tmo_r   <= tmo_next_s;
      class_r <= class_next_s;
      err_r   <= err_next_s;
      busy_r  <= busy_next_s;
      rd_en_r <= rd_en_next_s;
      addr_r  <= addr_next_s;
      fc_en_r <= fc_en_next_s;
      valid_r <= valid_next_s;
    end
  end

  // buffer data arrives one cycle after the read, exactly when the beat is streamed
  assign bus.fc_in     = (state_r == ST_STREAM) ? bus.mem_rdata : '0;
  assign bus.mem_rd_en = rd_en_r;
  assign bus.mem_addr  = addr_r;
  assign bus.fc_en     = fc_en_r;
  assign bus.res_valid = valid_r;
  assign bus.res_class = class_r;
  assign bus.res_err   = err_r;
  assign busy          = busy_r;

  assign fire_s = (state_r == ST_DONE) && bus.res_ready && !abort;

  fc_stat_counter #(.CW(CW)) u_normal (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (fire_s && !err_r && (class_r == CLS_NORMAL)),
    .cnt   (normal_cnt)
  );

  fc_stat_counter #(.CW(CW)) u_abnormal (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (fire_s && !err_r && (class_r == CLS_ABNORMAL)),
    .cnt   (abnormal_cnt)
  );

endmodule

// File: doc/fc_scheduler.md
Name: fc_scheduler

Overview:
Sequences one classification pass through the fully connected output layer. It streams the 64 int8 pooled features from the feature buffer, 4 lanes per beat over 16 beats, into the FC datapath. It then captures the FC class decision and hands it downstream with a valid/ready handshake. It also keeps saturating per-class statistics. It sits between the last pooling stage's feature buffer and the result/UART reporting logic.

Parameters:
LANES, 4, features per beat (FC input lanes)
DW, 8, bits per feature (signed int8)
BEATS, 16, beats per pass (LANES*BEATS = 64 features)
AW, 4, feature buffer address width (clog2(BEATS))
TIMEOUT, 8, cycles allowed in WAIT_RES before an error result
CW, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request a pass; accepted only in IDLE
abort  in  1  return to IDLE from any state; no result is produced
busy  out  1  high in every state except IDLE
mem_rd_en  out  1  feature buffer read strobe
mem_addr  out  AW  feature buffer beat address
mem_rdata  in  LANES*DW  buffer data, valid 1 cycle after mem_rd_en
fc_en  out  1  FC enable; low clears the FC accumulators
fc_in  out  LANES*DW  FC lane data, lane0 = bits [DW-1:0]
fc_outfin  in  2  FC decision: 0 = abnormal, 1 = normal, 2 = not ready
res_valid  out  1  result available
res_ready  in  1  downstream accepts the result
res_class  out  2  captured class (2 on error)
res_err  out  1  the result is a timeout error
stat_clr  in  1  synchronous clear of both counters
normal_cnt  out  CW  accepted normal results, saturating
abnormal_cnt  out  CW  accepted abnormal results, saturating

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - All outputs 0: busy, mem_rd_en, mem_addr, fc_en, fc_in, res_valid, res_class, res_err, normal_cnt, abnormal_cnt.
- States: IDLE, PREFETCH, STREAM, WAIT_RES, DONE.
- IDLE:
  - fc_en = 0.
  - start=1 and abort=0 -> PREFETCH.
- PREFETCH (1 cycle):
  - mem_rd_en = 1, mem_addr = 0, fc_en = 0.
  - -> STREAM with beat counter b = 0.
- STREAM (BEATS cycles, b = 0..BEATS-1):
  - fc_en = 1; fc_in = mem_rdata, which is beat b.
  - mem_rd_en = 1 and mem_addr = b+1 while b < BEATS-1; mem_rd_en = 0 on the last beat.
  - b = BEATS-1 -> WAIT_RES.
  - fc_in = 0 in every state other than STREAM.
- WAIT_RES:
  - fc_en is held at 1; dropping it would clear the FC.
  - Timeout counter t starts at 0.
  - fc_outfin != 2: res_class <= fc_outfin, res_err <= 0 -> DONE. Nominal case is the first WAIT_RES cycle.
  - t = TIMEOUT-1 with fc_outfin still 2: res_class <= 2, res_err <= 1 -> DONE.
- DONE:
  - res_valid = 1; fc_en is held at 1; res_class and res_err are stable.
  - res_ready=1 -> IDLE; fc_en is 0 in the following cycle.
  - res_ready may be high before res_valid; the handshake completes in the first DONE cycle.
- Latency: start-accept edge to res_valid high = 1 + BEATS + 1 = 18 cycles nominal.
- Statistics: updated on the handshake cycle (res_valid & res_ready) with res_err = 0.
  - res_class = 1 -> normal_cnt += 1; res_class = 0 -> abnormal_cnt += 1.
  - Each counter saturates at 2^CW-1.
  - Error results are not counted.
  - stat_clr takes priority over a same-cycle increment.
- abort=1 in any state:
  - -> IDLE on the next edge; fc_en, mem_rd_en and res_valid go low.
  - No statistics update, even if res_ready is high in the same cycle.
  - abort beats start.
- start while busy is ignored; it is not queued.
- res_class and res_err hold their last values in IDLE; they are only meaningful while res_valid is high.

Decomposition:
- Package fc_sched_pkg holds:
  - the state enum;
  - class constants CLS_ABNORMAL=0, CLS_NORMAL=1, CLS_NONE=2;
  - the defaults for LANES, DW and BEATS.
- One natural sub-module: fc_stat_counter, a saturating counter with clear and increment, instantiated twice.

Test Plan:
1. Reset, then start. Buffer beat k holds lanes {k,k,k,k}. Expect fc_in = beat k in STREAM cycle k, and res_valid exactly 18 cycles after accept. Model FC outfin=1 -> res_class=1, normal_cnt=1.
2. res_ready held low for 5 cycles in DONE, then pulsed. Expect res_valid and res_class stable throughout, one counter increment, and fc_en=0 in the cycle after the handshake.
3. FC model keeps outfin=2. Expect res_err=1 and res_class=2 after TIMEOUT cycles in WAIT_RES; counters unchanged after the handshake.
4. abort at STREAM beat 7. Expect busy=0, fc_en=0 and mem_rd_en=0 on the next cycle, no res_valid, and a following start to run a full clean pass.
5. Preload abnormal_cnt to 0xFFFF and complete a pass with outfin=0. Expect the counter to stay at 0xFFFF. Then stat_clr together with a handshake -> both counters 0.
6. Pulse start during WAIT_RES -> ignored, exactly one result. Assert rst_n mid-STREAM -> all outputs 0 immediately.
